drops_button_conditioner: RTL

Input stage of the drops game that sits directly upstream of the game core. It takes the two raw player buttons from the dedicated input pins (left = ui_in[1], right = ui_in[0]) and synchronises and debounces them. It then turns each press into single-cycle move commands, with optional hold-to-repeat, so the game core never sees metastable, bouncing or level-held inputs.

---
 rtl/drops_button_conditioner_if.sv | 36 +++
 rtl/drops_button_conditioner.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/drops_button_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module   : drops_button_conditioner_if
// Brief    : Button-conditioner signal bundle (raw buttons in, levels/moves out).
// Revision : 1.0
// ============================================================================
interface drops_button_conditioner_if;
    logic ena;
    logic btn_left_raw;
    logic btn_right_raw;
    logic left_level;
    logic right_level;
    logic move_left;
    logic move_right;

    modport master (
        output ena,
        output btn_left_raw,
        output btn_right_raw,
        input  left_level,
        input  right_level,
        input  move_left,
        input  move_right
    );

    modport slave (
        input  ena,
        input  btn_left_raw,
        input  btn_right_raw,
        output left_level,
        output right_level,
        output move_left,
        output move_right
    );
endinterface
`default_nettype wire

// File: rtl/drops_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : drops_button_conditioner
// Brief    : Sync + debounce of the two player buttons into one-cycle move
//            pulses; hold-to-repeat enabled by defining DROPS_AUTOREPEAT_EN.
// Revision : 1.0
// ============================================================================
module drops_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 2_500_000,
    parameter int REPEAT_RATE     = 1_000_000
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    drops_button_conditioner_if.slave bus
);
    localparam int         CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
`ifdef DROPS_AUTOREPEAT_EN
    localparam logic [1:0] ST_REPEAT = 2'd2;
    localparam int         TMR_MAX   = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int         TMR_W     = $clog2(TMR_MAX);
    localparam logic [TMR_W-1:0] DELAY_LD = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] RATE_LD  = TMR_W'(REPEAT_RATE - 1);
`endif

    // Elaboration leaves this marker when a parameter is below its minimum.
    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_RATE < 2) begin : g_param_range_error
    end

    // Bit 1 is the left channel, bit 0 the right channel.
    logic [1:0] raw;
    logic [1:0] level_d;
    logic [1:0] level_q;
    logic [1:0] pulse;
    logic [1:0] move_d;
    logic [1:0] move_q;
    logic       both_d;

    assign raw    = {bus.btn_left_raw, bus.btn_right_raw};
    assign both_d = &level_d;
    assign move_d = pulse & {2{bus.ena}};

`ifdef DROPS_AUTOREPEAT_EN
    logic both_q;
    assign both_q = &level_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= '0;
            move_q  <= '0;
        end else begin
            level_q <= level_d;
            move_q  <= move_d;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_ch
        logic             sync1_d, sync1_q;
        logic             sync2_d, sync2_q;
        logic [CNT_W-1:0] cnt_d, cnt_q;
        logic             lvl_d;
        logic [1:0]       state_d, state_q;
        logic             pulse_c;

        always_comb begin
            sync1_d = raw[i];
            sync2_d = sync1_q;
            cnt_d   = '0;
            lvl_d   = level_q[i];
            if (sync2_q != level_q[i]) begin
                if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    lvl_d = ~level_q[i];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        assign level_d[i] = lvl_d;
        assign pulse[i]   = pulse_c;

`ifdef DROPS_AUTOREPEAT_EN
        logic [TMR_W-1:0] timer_d, timer_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
                cnt_q   <= '0;
                state_q <= ST_IDLE;
                timer_q <= '0;
            end else begin
                sync1_q <= sync1_d;
                sync2_q <= sync2_d;
                cnt_q   <= cnt_d;
                state_q <= state_d;
                timer_q <= timer_d;
            end
        end

        // The cycle after a conflict ends still reloads, so the survivor
        // restarts its full delay from the release edge.
        always_comb begin
            state_d = state_q;
            timer_d = timer_q;
            if (!lvl_d) begin
                state_d = ST_IDLE;
                timer_d = '0;
            end else if (both_d || both_q || state_q == ST_IDLE) begin
                state_d = ST_HOLD;
                timer_d = DELAY_LD;
            end else if (timer_q == '0) begin
                state_d = ST_REPEAT;
                timer_d = RATE_LD;
            end else begin
                timer_d = timer_q - 1'b1;
            end
        end

        always_comb begin
            pulse_c = 1'b0;
            if (lvl_d && !both_d && !both_q) begin
                pulse_c = (state_q == ST_IDLE) || (timer_q == '0);
            end
        end
`else
        always_ff @(posedge clk) begin
            if (rst) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
                cnt_q   <= '0;
                state_q <= ST_IDLE;
            end else begin
                sync1_q <= sync1_d;
                sync2_q <= sync2_d;
                cnt_q   <= cnt_d;
                state_q <= state_d;
            end
        end

        always_comb begin
            state_d = lvl_d ? ST_HOLD : ST_IDLE;
        end

        always_comb begin
            pulse_c = lvl_d && !both_d && (state_q == ST_IDLE);
        end
`endif
    end

    assign bus.left_level  = level_q[1];
    assign bus.right_level = level_q[0];
    assign bus.move_left   = move_q[1];
    assign bus.move_right  = move_q[0];
endmodule
`default_nettype wire
